uart_rx: RTL and testbench

//  Asynchronous serial receiver, 8N1, LSB first; counterpart to the UART transmit path
//  and consumer of the baud-rate timing. Oversamples the rx pin 16x with an internal

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encoding and vote helper
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

  // Two-of-three vote used for the mid-bit decision.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick enable with sync clear
module uart_baud_tick #(
  parameter int TICK_DIV = 326
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..TICK_DIV-1; clear realigns the phase to the start edge.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear cycle never produces a tick, so the new phase starts clean.
  assign tick_o = (cnt_q == CNT_MAX) && !clr_i;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver, 16x oversampled, 1-entry valid/ready holder
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV = 326
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [SAMPLE_W-1:0]  S_FIRST = SAMPLE_W'(MID_SAMPLE - 1);
  localparam logic [SAMPLE_W-1:0]  S_MID   = SAMPLE_W'(MID_SAMPLE);
  localparam logic [SAMPLE_W-1:0]  S_DEC   = SAMPLE_W'(MID_SAMPLE + 1);
  localparam logic [SAMPLE_W-1:0]  S_LAST  = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rxs_q;
  uart_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0]  s_q, s_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [1:0]           smp_q, smp_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, tick_clr, byte_done, decision;
  logic at_first, at_mid, at_dec, at_end;

  uart_baud_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign at_first = tick && (s_q == S_FIRST);
  assign at_mid   = tick && (s_q == S_MID);
  assign at_dec   = tick && (s_q == S_DEC);
  assign at_end   = tick && (s_q == S_LAST);
  // The third vote is the live synced level at the decision tick.
  assign decision = majority3(smp_q[1], smp_q[0], rxs_q);

  // Frame FSM: sample counter, vote capture, shifter and completion strobes.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    tick_clr    = 1'b0;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;

    if ((state_q != ST_IDLE) && tick) begin
      s_d = s_q + SAMPLE_W'(1);
      if (at_first) smp_d[1] = rxs_q;
      if (at_mid)   smp_d[0] = rxs_q;
    end

    case (state_q)
      ST_IDLE: begin
        s_d = '0;
        if (!rxs_q) begin
          state_d  = ST_START;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        if (at_dec && decision) begin
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (at_dec) begin
          shreg_d = {decision, shreg_q[7:1]};
        end
        if (at_end) begin
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a following start edge is caught in time.
        if (at_dec) begin
          state_d = ST_IDLE;
          if (decision) begin
            byte_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      smp_q       <= 2'b11;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      smp_q       <= smp_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Holding register: load when empty or being drained, else flag overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (byte_done) begin
      if (!valid_q || ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at TICK_DIV=4
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted byte is popped and compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (valid && ready) begin
        rx_cnt++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            n_fail++;
            $display("FAIL byte_data: got %0h expected %0h", data, e);
          end
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int jit, input bit spike);
    logic [9:0] bits;
    int pj, nj, dur;
    bits = {stop, d, 1'b0};
    pj = 0;
    for (int k = 0; k < 10; k++) begin
      nj  = (jit > 0 && k < 9) ? int'($urandom_range(2 * jit)) - jit : 0;
      dur = BIT_CLK + nj - pj;
      rx  = bits[k];
      if (spike && k >= 1 && k <= 8) begin
        hold(32);
        rx = ~bits[k];
        hold(1);
        rx = bits[k];
        hold(dur - 33);
      end else begin
        hold(dur);
      end
      pj = nj;
    end
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         jit;
    bit         spike;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0, f0, o0;

    vecs[0] = '{8'hA5, 1'b1, 0, 1'b0, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 0, 1'b0, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 2, 1'b1, 1, 0};
    vecs[5] = '{8'h3C, 1'b1, 2, 1'b0, 1, 0};

    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    hold(3);
    check("reset_outputs", {data, valid, frame_err, overrun, busy}, 32'h0);
    reset = 1'b0;
    hold(10);

    // Table-driven frames with ready held high.
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r0 = rx_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      if (vecs[i].exp_bytes != 0) exp_q.push_back(vecs[i].d);
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].jit, vecs[i].spike);
      hold(100);
      check($sformatf("vec%0d_bytes", i), rx_cnt - r0, vecs[i].exp_bytes);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
      check($sformatf("vec%0d_idle", i), {valid, busy}, 2'b00);
    end

    // Back-to-back frames with no consumer: second byte overruns.
    ready = 1'b0;
    r0 = rx_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    send_frame(8'hC3, 1'b1, 0, 1'b0);
    hold(100);
    check("b2b_valid_held", valid, 1'b1);
    check("b2b_data_held", data, 8'h3C);
    check("b2b_overrun_once", ovr_cnt - o0, 1);
    check("b2b_no_ferr", ferr_cnt - f0, 0);
    ready = 1'b1;
    hold(3);
    check("b2b_valid_drop", valid, 1'b0);
    check("b2b_one_byte", rx_cnt - r0, 1);
    n_tests++;
    if (data === 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_data_not_c3: got %0h expected not c3", data);
    end

    // Short low glitch: start rejected, no flags.
    r0 = rx_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    hold(20);
    rx = 1'b1;
    hold(2);
    check("glitch_busy", busy, 1'b1);
    hold(80);
    check("glitch_idle", busy, 1'b0);
    check("glitch_no_byte", rx_cnt - r0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Mid-frame reset with a held byte, then recovery.
    ready = 1'b0;
    send_frame(8'h12, 1'b1, 0, 1'b0);
    hold(40);
    check("pre_reset_held", {valid, data}, {1'b1, 8'h12});
    rx = 1'b0;
    hold(BIT_CLK);
    rx = 1'b1; hold(BIT_CLK);
    rx = 1'b0; hold(BIT_CLK);
    rx = 1'b1; hold(40);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    hold(1);
    check("reset_mid_outputs", {data, valid, frame_err, overrun, busy}, 32'h0);
    hold(3);
    check("reset_hold_outputs", {data, valid, frame_err, overrun, busy}, 32'h0);
    reset = 1'b0;
    hold(100);
    check("post_reset_idle", {valid, busy}, 2'b00);
    r0 = rx_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    ready = 1'b1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 0, 1'b0);
    hold(100);
    check("post_reset_byte", rx_cnt - r0, 1);
    check("post_reset_flags", {ferr_cnt - f0, ovr_cnt - o0}, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
